// File: rtl/ulaplus_palette.sv
// ULA+ palette responder: 64x8 colour store behind one shared access port,
// arbitrating CPU read/write pulses against per-pixel video lookups.
module ulaplus_palette #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic       read_req,
  input  logic       write_req,
  input  logic [5:0] rw_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       pix_valid,
  input  logic       pix_ink,
  input  logic [7:0] pix_attr,
  input  logic       pix_border,
  input  logic [2:0] border_idx,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b,
  output logic       rgb_valid,
  output logic       pix_stall
);

  // state   | meaning
  // ST_IDLE | no CPU request waiting for the port
  // ST_PEND | CPU request held back by video lookups, r_wait counts the blocked cycles

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_wait;
  logic [CW-1:0]   w_wait_nxt;
  logic            r_pend_wr;
  logic [5:0]      r_pend_addr;
  logic [7:0]      r_pend_data;
  logic [7:0]      r_mem [64];

  logic            w_incoming;
  logic            w_cpu_have;
  logic            w_req_wr;
  logic [5:0]      w_req_addr;
  logic [7:0]      w_req_data;
  logic [CW-1:0]   w_eff_wait;
  logic            w_vid_req;
  logic            w_forced;
  logic            w_cpu_grant;
  logic            w_vid_grant;
  logic [5:0]      w_pix_idx;
  logic [5:0]      w_port_addr;
  logic [7:0]      w_port_q;

  assign w_incoming = read_req | write_req;
  assign w_cpu_have = w_incoming | (r_state == ST_PEND);

  // A fresh request overrides the pending one; write wins over a same-cycle read.
  assign w_req_wr   = w_incoming ? write_req : r_pend_wr;
  assign w_req_addr = w_incoming ? rw_addr   : r_pend_addr;
  assign w_req_data = w_incoming ? wr_data   : r_pend_data;
  assign w_eff_wait = w_incoming ? '0        : r_wait;

  assign w_vid_req   = en & pix_valid;
  assign w_forced    = w_cpu_have & w_vid_req & (w_eff_wait == LIMIT);
  assign w_cpu_grant = w_cpu_have & (~w_vid_req | w_forced);
  assign w_vid_grant = w_vid_req & ~w_cpu_grant;

  assign w_pix_idx = pix_border ? {3'b001, border_idx}
                                : {pix_attr[7], pix_attr[6], ~pix_ink,
                                   pix_ink ? pix_attr[2:0] : pix_attr[5:3]};

  assign w_port_addr = w_cpu_grant ? w_req_addr : w_pix_idx;
  assign w_port_q    = r_mem[w_port_addr];

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    if (w_cpu_grant) begin
      w_state_nxt = ST_IDLE;
      w_wait_nxt  = '0;
    end else if (w_cpu_have) begin
      w_state_nxt = ST_PEND;
      w_wait_nxt  = (w_eff_wait == LIMIT) ? LIMIT : w_eff_wait + 1'b1;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_pend_wr   <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_incoming) begin
        r_pend_wr   <= write_req;
        r_pend_addr <= rw_addr;
        r_pend_data <= wr_data;
      end
    end
  end

  // Palette contents survive reset, so the store has no reset branch.
  always_ff @(posedge clk28) begin
    if (w_cpu_grant && w_req_wr)
      r_mem[w_req_addr] <= w_req_data;
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      rgb_valid <= 1'b0;
      pix_stall <= 1'b0;
    end else begin
      rd_valid  <= w_cpu_grant & ~w_req_wr;
      if (w_cpu_grant && !w_req_wr)
        rd_data <= w_port_q;
      // A forced CPU grant repeats the previous pixel and flags it.
      rgb_valid <= w_vid_grant | w_forced;
      pix_stall <= w_forced;
      if (w_vid_grant) begin
        g <= w_port_q[7:5];
        r <= w_port_q[4:2];
        b <= {w_port_q[1], w_port_q[0], w_port_q[1] | w_port_q[0]};
      end
    end
  end

endmodule

// File: tb/tb_ulaplus_palette.sv
// Directed bench for ulaplus_palette: CPU access, colour decode, starvation,
// en gating and asynchronous reset with a request pending.
module tb_ulaplus_palette;

  logic       clk28;
  logic       rst;
  logic       en;
  logic       read_req;
  logic       write_req;
  logic [5:0] rw_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       pix_valid;
  logic       pix_ink;
  logic [7:0] pix_attr;
  logic       pix_border;
  logic [2:0] border_idx;
  logic [2:0] r;
  logic [2:0] g;
  logic [2:0] b;
  logic       rgb_valid;
  logic       pix_stall;

  int checks = 0;
  int errors = 0;

  ulaplus_palette #(.STARVE_LIMIT(4)) dut (
    .clk28(clk28), .rst(rst), .en(en),
    .read_req(read_req), .write_req(write_req),
    .rw_addr(rw_addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .pix_valid(pix_valid), .pix_ink(pix_ink), .pix_attr(pix_attr),
    .pix_border(pix_border), .border_idx(border_idx),
    .r(r), .g(g), .b(b), .rgb_valid(rgb_valid), .pix_stall(pix_stall)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags = {rd_valid, rgb_valid, pix_stall}
  task automatic chk_flags(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {rd_valid, rgb_valid, pix_stall};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s flags rd/rgb/stall observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [2:0] er, input logic [2:0] eg,
                         input logic [2:0] eb);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {r, g, b};
    exp = {er, eg, eb};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s rgb observed %o expected %o", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    read_req  = 1'b0;
    write_req = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    write_req = 1'b1;
    rw_addr   = a;
    wr_data   = d;
  endtask

  task automatic cpu_read(input logic [5:0] a);
    read_req = 1'b1;
    rw_addr  = a;
  endtask

  task automatic pix_normal(input logic [7:0] attr, input logic ink);
    pix_valid  = 1'b1;
    pix_border = 1'b0;
    pix_attr   = attr;
    pix_ink    = ink;
  endtask

  task automatic pix_bord(input logic [2:0] idx);
    pix_valid  = 1'b1;
    pix_border = 1'b1;
    border_idx = idx;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    read_req = 1'b0; write_req = 1'b0; rw_addr = '0; wr_data = '0;
    pix_valid = 1'b0; pix_ink = 1'b0; pix_attr = '0; pix_border = 1'b0; border_idx = '0;
    tick(); tick();
    chk8("reset_rd_data", rd_data, 8'h00);
    chk_flags("reset_flags", 3'b000);
    chk_rgb("reset_rgb", 3'd0, 3'd0, 3'd0);
    rst = 1'b0;
    tick();

    // write then read back
    cpu_write(6'h05, 8'hE3); tick();
    chk_flags("write_no_rdvalid", 3'b000);
    idle_in(); tick();
    cpu_read(6'h05); tick();
    chk_flags("read_rdvalid", 3'b100);
    chk8("read_data", rd_data, 8'hE3);
    idle_in(); tick();
    chk_flags("rdvalid_one_cycle", 3'b000);
    chk8("rd_data_hold", rd_data, 8'hE3);

    // write then lookups: ink index 0x32, paper index 0x2A
    cpu_write(6'h32, 8'h1C); tick();
    cpu_write(6'h2A, 8'hFF); tick();
    idle_in();
    pix_normal(8'hC2, 1'b1); tick();
    chk_flags("lookup_ink_valid", 3'b010);
    chk_rgb("lookup_ink_rgb", 3'd7, 3'd0, 3'd0);
    pix_normal(8'h90, 1'b0); tick();
    chk_rgb("lookup_paper_rgb", 3'd7, 3'd7, 3'd7);
    idle_in(); tick();
    chk_flags("no_lookup_no_rgbvalid", 3'b000);

    // border pixel and blue expansion
    cpu_write(6'h0B, 8'h01); tick();
    idle_in();
    pix_bord(3'd3); tick();
    chk_flags("border_valid", 3'b010);
    chk_rgb("border_rgb", 3'd0, 3'd0, 3'd3);

    // starvation: write to the entry under continuous lookup
    pix_normal(8'hC2, 1'b1);
    cpu_write(6'h32, 8'hE3); tick();
    write_req = 1'b0;
    chk_flags("starve_c0", 3'b010);
    chk_rgb("starve_c0_rgb", 3'd7, 3'd0, 3'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_flags("starve_wait", 3'b010);
      chk_rgb("starve_wait_old", 3'd7, 3'd0, 3'd0);
    end
    tick();
    chk_flags("starve_stall", 3'b011);
    chk_rgb("starve_repeat", 3'd7, 3'd0, 3'd0);
    tick();
    chk_flags("starve_after", 3'b010);
    chk_rgb("starve_new_val", 3'd0, 3'd7, 3'd7);

    // pending request released by a pix_valid gap: no stall
    cpu_write(6'h32, 8'h1C); tick();
    write_req = 1'b0;
    pix_valid = 1'b0; tick();
    chk_flags("gap_grant_no_stall", 3'b000);
    pix_normal(8'hC2, 1'b1); tick();
    chk_rgb("gap_written", 3'd7, 3'd0, 3'd0);

    // en=0: no lookups, CPU served immediately
    en = 1'b0;
    tick();
    chk_flags("en0_no_rgb", 3'b000);
    cpu_read(6'h05); tick();
    chk_flags("en0_read", 3'b100);
    chk8("en0_read_data", rd_data, 8'hE3);
    read_req = 1'b1; write_req = 1'b1; rw_addr = 6'h0B; wr_data = 8'h55; tick();
    read_req = 1'b0; write_req = 1'b0;
    chk_flags("both_req_no_rdvalid", 3'b000);
    pix_valid = 1'b0;
    cpu_read(6'h0B); tick();
    read_req = 1'b0;
    chk8("both_req_write_taken", rd_data, 8'h55);
    en = 1'b1;
    pix_bord(3'd3); tick();
    chk_rgb("en1_border_55", 3'd5, 3'd2, 3'd3);
    pix_normal(8'hC2, 1'b1); tick();
    chk_rgb("en_toggle_kept", 3'd7, 3'd0, 3'd0);

    // reset with a write pending on 0x32
    cpu_write(6'h32, 8'h00); tick();
    write_req = 1'b0;
    tick();
    chk_flags("pre_reset_valid", 3'b010);
    rst = 1'b1;
    #2;
    chk_flags("async_reset_flags", 3'b000);
    chk_rgb("async_reset_rgb", 3'd0, 3'd0, 3'd0);
    chk8("async_reset_rd", rd_data, 8'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_flags("post_reset_no_stall", 3'b010);
      chk_rgb("post_reset_old", 3'd7, 3'd0, 3'd0);
    end
    pix_valid = 1'b0;
    cpu_read(6'h32); tick();
    read_req = 1'b0;
    chk_flags("post_reset_read", 3'b100);
    chk8("post_reset_retained", rd_data, 8'h1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
